sr_bank_write_arbiter: RTL

Two-port write controller for a bank of N SR flip-flops. It accepts SET, CLR, TOGGLE and HOLD requests from two requesters and shares the bank between them using round-robin arbitration. It converts each granted request into a single-cycle S or R pulse on one bit, and guarantees S and R are never both asserted on any bit. It then reads the bit back and flags any mismatch.

---
 rtl/sr_bank_write_arbiter_pkg.sv | 28 ++
 rtl/sr_bank_write_arbiter_sr_ff_bank.sv | 30 +++
 rtl/sr_bank_write_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/sr_bank_write_arbiter_pkg.sv
// Shared definitions for the SR bank write arbiter.
// Holds the request opcode encoding, the controller FSM state encoding and
// a helper that gives the bit value a command is expected to leave behind.
package sr_bank_write_arbiter_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TOG  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Value the target bit should hold once the command has been applied,
  // given the bit's current readback value.
  function automatic logic op_target(input logic [1:0] op, input logic cur);
    case (op)
      OP_SET:  return 1'b1;
      OP_CLR:  return 1'b0;
      OP_TOG:  return ~cur;
      default: return cur;
    endcase
  endfunction

endpackage

// File: rtl/sr_bank_write_arbiter_sr_ff_bank.sv
// Bank of N SR flip-flops.
// Each bit powers up at 1 and has no reset, so it keeps its value across
// controller resets. A set pulse forces the bit to 1, a reset pulse to 0;
// with neither the bit holds.
// Ports:
//   clk : clock, bits update on the rising edge
//   s   : per-bit set lines
//   r   : per-bit reset lines
//   q   : per-bit state
module sr_ff_bank #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic [N-1:0] s,
  input  logic [N-1:0] r,
  output logic [N-1:0] q
);

  // Power-up value only; these flops are intentionally never reset.
  logic [N-1:0] q_reg = '1;

  // Set is applied after reset so a bit with both lines high would end at 1;
  // the controller guarantees that never happens.
  always_ff @(posedge clk) begin
    q_reg <= (q_reg & ~r) | s;
  end

  assign q = q_reg;

endmodule

// File: rtl/sr_bank_write_arbiter.sv
// Two-port round-robin write controller for a bank of N SR flip-flops.
// Each accepted command becomes a single-cycle set or reset pulse on one
// bit, after which the bit is read back and any mismatch raises a sticky
// error. One command completes every three cycles: accept, drive, check.
// Ports:
//   clk, rst_n                 : clock and synchronous active-low reset
//   req0_valid/idx/op, ready   : requester 0 command handshake
//   req1_valid/idx/op, ready   : requester 1 command handshake
//   q_in                       : bank readback
//   s_out, r_out               : bank set/reset lines (registered)
//   done, done_id              : completion pulse and owning requester
//   err, err_clr               : sticky readback/index error and its clear
// IDXW must be wide enough that 2**IDXW >= N.
module sr_bank_write_arbiter
  import sr_bank_write_arbiter_pkg::*;
#(
  parameter int N    = 8,
  parameter int IDXW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic [IDXW-1:0] req0_idx,
  input  logic [1:0]      req0_op,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [IDXW-1:0] req1_idx,
  input  logic [1:0]      req1_op,
  output logic            req1_ready,
  input  logic [N-1:0]    q_in,
  output logic [N-1:0]    s_out,
  output logic [N-1:0]    r_out,
  output logic            done,
  output logic            done_id,
  output logic            err,
  input  logic            err_clr
);

  localparam logic [N-1:0] ONE = N'(1);

  state_t          state, state_next;
  logic            rr_ptr, rr_ptr_next;
  logic [IDXW-1:0] idx_q, idx_next;
  logic            id_q, id_next;
  logic            target_q, target_next;
  logic [N-1:0]    s_next, r_next;
  logic            done_next, done_id_next;
  logic            err_set, err_next;

  logic            grant0, grant1, accept;
  logic [IDXW-1:0] sel_idx;
  logic [1:0]      sel_op;
  logic [N-1:0]    sel_onehot, chk_onehot;
  logic            sel_q, sel_target, chk_q, mismatch;

  // Round robin: a lone requester always wins; with both present, rr_ptr
  // names the favoured one (0 = req0). A shift past the top of the bank
  // yields an all-zero one-hot, which doubles as the out-of-range flag.
  always_comb begin
    grant1     = req1_valid && (!req0_valid || rr_ptr);
    grant0     = req0_valid && !grant1;
    req0_ready = (state == IDLE) && grant0;
    req1_ready = (state == IDLE) && grant1;
    accept     = req0_ready || req1_ready;
    sel_idx    = grant1 ? req1_idx : req0_idx;
    sel_op     = grant1 ? req1_op  : req0_op;
    sel_onehot = ONE << sel_idx;
    sel_q      = |(q_in & sel_onehot);
    sel_target = op_target(sel_op, sel_q);
    chk_onehot = ONE << idx_q;
    chk_q      = |(q_in & chk_onehot);
    mismatch   = (chk_onehot != '0) && (chk_q != target_q);
  end

  // Next-state and next-output logic. Pulses are decided at accept and
  // registered, so they appear for exactly the DRIVE cycle; done likewise
  // appears for exactly the CHECK cycle.
  always_comb begin
    state_next   = state;
    rr_ptr_next  = rr_ptr;
    idx_next     = idx_q;
    id_next      = id_q;
    target_next  = target_q;
    s_next       = '0;
    r_next       = '0;
    done_next    = 1'b0;
    done_id_next = done_id;
    err_set      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next  = DRIVE;
          rr_ptr_next = grant0;
          idx_next    = sel_idx;
          id_next     = grant1;
          target_next = sel_target;
          err_set     = (sel_onehot == '0);
          case (sel_op)
            OP_SET:  s_next = sel_onehot;
            OP_CLR:  r_next = sel_onehot;
            OP_TOG: begin
              if (sel_target) s_next = sel_onehot;
              else            r_next = sel_onehot;
            end
            default: ;
          endcase
        end
      end
      DRIVE: begin
        state_next   = CHECK;
        done_next    = 1'b1;
        done_id_next = id_q;
      end
      CHECK: begin
        state_next = IDLE;
        err_set    = mismatch;
      end
      default: state_next = IDLE;
    endcase
    // A newly detected error beats a simultaneous clear.
    if (err_set)      err_next = 1'b1;
    else if (err_clr) err_next = 1'b0;
    else              err_next = err;
  end

  // State and output registers. Reset cancels any command in flight but
  // cannot undo a pulse the bank has already sampled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      idx_q    <= '0;
      id_q     <= 1'b0;
      target_q <= 1'b0;
      s_out    <= '0;
      r_out    <= '0;
      done     <= 1'b0;
      done_id  <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      rr_ptr   <= rr_ptr_next;
      idx_q    <= idx_next;
      id_q     <= id_next;
      target_q <= target_next;
      s_out    <= s_next;
      r_out    <= r_next;
      done     <= done_next;
      done_id  <= done_id_next;
      err      <= err_next;
    end
  end

  // Set and reset must never overlap on any bit.
  assert property (@(posedge clk) (s_out & r_out) == '0);

endmodule
